// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - game-state controller: button debounce, collision detect, IDLE/RUN/DEAD FSM
//
// Ports:
//   clk         pixel clock (25.175 MHz)
//   reset       synchronous, active-high reset
//   btn         raw asynchronous jump/start button, active-high
//   vaddress    current VGA line
//   haddress    current VGA column
//   dino_px     dino sprite pixel at (haddress, vaddress)
//   obst_px     obstacle pixel at (haddress, vaddress)
//   halt        freeze score and scrolling (1 whenever state != RUN)
//   game_reset  one-cycle pulse on every game start
//   jump        one-cycle pulse per debounced press while running
//   state       0 = IDLE, 1 = RUN, 2 = DEAD
//
// Optional feature macro: COLLISION_FILTER_EN
//   When defined, a per-frame overlap counter must reach MIN_OVERLAP
//   before a collision kills the dino; otherwise one overlapping pixel does.

module game_ctrl #(
    parameter int DEBOUNCE_CYCLES = 251750,
    parameter int LOCKOUT_CYCLES  = 12587500,
    parameter int MIN_OVERLAP     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    input  logic [9:0] vaddress,
    input  logic [9:0] haddress,
    input  logic       dino_px,
    input  logic       obst_px,
    output logic       halt,
    output logic       game_reset,
    output logic       jump,
    output logic [1:0] state
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LK_W = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [LK_W-1:0] LK_MAX = LK_W'(LOCKOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Button path: two-flop synchronizer, debounce counter, edge detect
    // ------------------------------------------------------------------
    logic            btn_s1;
    logic            btn_s2;
    logic            db_level;
    logic            db_level_q;
    logic [DB_W-1:0] db_cnt;
    logic            press;

    // The counter runs while the synchronized level disagrees with the
    // debounced level. The debounced level flips one cycle after the
    // disagreement has lasted past DEBOUNCE_CYCLES-1, so any glitch of
    // DEBOUNCE_CYCLES cycles or fewer is absorbed.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_s1     <= 1'b0;
            btn_s2     <= 1'b0;
            db_level   <= 1'b0;
            db_level_q <= 1'b0;
            db_cnt     <= '0;
        end else begin
            btn_s1     <= btn;
            btn_s2     <= btn_s1;
            db_level_q <= db_level;
            if (btn_s2 != db_level) begin
                if (db_cnt == DB_MAX) begin
                    db_level <= btn_s2;
                    db_cnt   <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign press = db_level & ~db_level_q;

    // ------------------------------------------------------------------
    // Collision: overlap only counts inside the visible 640x480 area
    // ------------------------------------------------------------------
    logic hit;
    logic kill;

    assign hit = dino_px & obst_px & (vaddress < 10'd480) & (haddress < 10'd640);

    // ------------------------------------------------------------------
    // Game FSM
    // ------------------------------------------------------------------
    state_t          state_q;
    state_t          state_n;
    logic            halt_q;
    logic            halt_n;
    logic            game_reset_q;
    logic            game_reset_n;
    logic            jump_q;
    logic            jump_n;
    logic [LK_W-1:0] lock_q;
    logic [LK_W-1:0] lock_n;

`ifdef COLLISION_FILTER_EN
    logic [9:0] ovl_q;
    logic       frame_start;

    assign frame_start = (vaddress == 10'd0) && (haddress == 10'd0);
    // Compare against the registered count: death lands one cycle after
    // the count reaches the threshold.
    assign kill = (ovl_q >= 10'(MIN_OVERLAP));

    always_ff @(posedge clk) begin
        if (reset) begin
            ovl_q <= '0;
        end else if (frame_start || game_reset_n) begin
            ovl_q <= '0;
        end else if ((state_q == RUN) && hit && (ovl_q != 10'd1023)) begin
            ovl_q <= ovl_q + 10'd1;
        end
    end
`else
    assign kill = hit;
`endif

    always_comb begin
        state_n      = state_q;
        game_reset_n = 1'b0;
        jump_n       = 1'b0;
        lock_n       = lock_q;
        case (state_q)
            IDLE: begin
                if (press) begin
                    state_n      = RUN;
                    game_reset_n = 1'b1;
                end
            end
            RUN: begin
                // A hit wins over a simultaneous press: no jump on death.
                if (kill) begin
                    state_n = DEAD;
                    lock_n  = '0;
                end else if (press) begin
                    jump_n = 1'b1;
                end
            end
            DEAD: begin
                if (lock_q != LK_MAX) begin
                    lock_n = lock_q + 1'b1;
                end
                if (press && (lock_q == LK_MAX)) begin
                    state_n      = RUN;
                    game_reset_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        halt_n = (state_n != RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            halt_q       <= 1'b1;
            game_reset_q <= 1'b0;
            jump_q       <= 1'b0;
            lock_q       <= '0;
        end else begin
            state_q      <= state_n;
            halt_q       <= halt_n;
            game_reset_q <= game_reset_n;
            jump_q       <= jump_n;
            lock_q       <= lock_n;
        end
    end

    assign state      = state_q;
    assign halt       = halt_q;
    assign game_reset = game_reset_q;
    assign jump       = jump_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - directed self-checking bench for game_ctrl

module tb_game_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn;
    logic [9:0] vaddress;
    logic [9:0] haddress;
    logic       dino_px;
    logic       obst_px;
    logic       halt;
    logic       game_reset;
    logic       jump;
    logic [1:0] state;

    int n_checks = 0;
    int n_pass   = 0;

    game_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .LOCKOUT_CYCLES (16),
        .MIN_OVERLAP    (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn       (btn),
        .vaddress  (vaddress),
        .haddress  (haddress),
        .dino_px   (dino_px),
        .obst_px   (obst_px),
        .halt      (halt),
        .game_reset(game_reset),
        .jump      (jump),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pix_on();
        haddress = 10'd100;
        vaddress = 10'd200;
        dino_px  = 1'b1;
        obst_px  = 1'b1;
    endtask

    task automatic pix_off();
        haddress = 10'd5;
        vaddress = 10'd5;
        dino_px  = 1'b0;
        obst_px  = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, int'(state), 0);
        check({tag, "_halt"}, int'(halt), 1);
        check({tag, "_greset"}, int'(game_reset), 0);
        check({tag, "_jump"}, int'(jump), 0);
    endtask

    // Drives a collision while in RUN; returns in the first DEAD cycle.
    task automatic kill(input string tag);
`ifdef COLLISION_FILTER_EN
        haddress = 10'd0; vaddress = 10'd0; dino_px = 1'b0; obst_px = 1'b0;
        tick();
        pix_on();
        ticks(2);
        pix_off();
        ticks(2);
        check({tag, "_two_hits_run"}, int'(state), 1);
        haddress = 10'd0; vaddress = 10'd0;
        tick();
        pix_on();
        ticks(3);
        pix_off();
        check({tag, "_third_hit_run"}, int'(state), 1);
        tick();
        check({tag, "_dead"}, int'(state), 2);
        check({tag, "_halt"}, int'(halt), 1);
`else
        pix_on();
        tick();
        pix_off();
        check({tag, "_dead"}, int'(state), 2);
        check({tag, "_halt"}, int'(halt), 1);
`endif
    endtask

    initial begin
        int bad;
        reset = 1'b1; btn = 1'b0; dino_px = 1'b0; obst_px = 1'b0;
        haddress = 10'd5; vaddress = 10'd5;

        // 1: reset values, short glitch ignored
        ticks(2);
        reset = 1'b0;
        tick();
        check_reset_vals("rst");
        btn = 1'b1;
        ticks(3);
        btn = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (state != 2'd0 || game_reset || jump || !halt) bad++;
        end
        check("glitch_ignored", bad, 0);

        // 2: start latency, then a jump
        btn = 1'b1;
        ticks(7);
        check("start_c6_state", int'(state), 0);
        check("start_c6_greset", int'(game_reset), 0);
        tick();
        check("start_c7_greset", int'(game_reset), 1);
        check("start_c7_state", int'(state), 1);
        check("start_c7_halt", int'(halt), 0);
        tick();
        check("start_c8_greset", int'(game_reset), 0);
        check("start_c8_state", int'(state), 1);
        btn = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (jump || game_reset) bad++;
        end
        check("release_no_pulse", bad, 0);
        btn = 1'b1;
        ticks(7);
        check("jump_c6", int'(jump), 0);
        tick();
        check("jump_c7", int'(jump), 1);
        check("jump_c7_greset", int'(game_reset), 0);
        tick();
        check("jump_c8", int'(jump), 0);
        btn = 1'b0;
        ticks(10);

        // 3: overlap outside active area, then inside
        haddress = 10'd700; vaddress = 10'd200; dino_px = 1'b1; obst_px = 1'b1;
        tick();
        check("offscreen_h", int'(state), 1);
        haddress = 10'd100; vaddress = 10'd500;
        tick();
        check("offscreen_v", int'(state), 1);
        pix_off();
        kill("hit");

        // 4: lockout
        ticks(3);
        btn = 1'b1;
        ticks(7);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (state != 2'd2 || game_reset) bad++;
        end
        check("lockout_press_ignored", bad, 0);
        btn = 1'b0;
        ticks(10);
        btn = 1'b1;
        ticks(7);
        check("restart_c6_state", int'(state), 2);
        tick();
        check("restart_state", int'(state), 1);
        check("restart_greset", int'(game_reset), 1);
        btn = 1'b0;
        ticks(10);
        btn = 1'b1;
        ticks(10);
        kill("held");
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (state != 2'd2 || game_reset) bad++;
        end
        check("held_stays_dead", bad, 0);
        btn = 1'b0;
        ticks(10);
        btn = 1'b1;
        ticks(8);
        check("fresh_restart_state", int'(state), 1);
        check("fresh_restart_greset", int'(game_reset), 1);
        btn = 1'b0;
        ticks(10);

        // 5: press and hit together, resets mid-pulse and mid-lockout
`ifndef COLLISION_FILTER_EN
        btn = 1'b1;
        ticks(7);
        pix_on();
        tick();
        pix_off();
        check("press_hit_state", int'(state), 2);
        check("press_hit_jump", int'(jump), 0);
`else
        btn = 1'b1;
        ticks(10);
        kill("press_hit");
`endif
        btn = 1'b0;
        ticks(20);
        btn = 1'b1;
        ticks(8);
        check("pre_rst_greset", int'(game_reset), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_vals("rst_pulse");
        btn = 1'b0;
        ticks(10);
        check("rst_pulse_idle", int'(state), 0);
        btn = 1'b1;
        ticks(8);
        check("ml_start", int'(state), 1);
        btn = 1'b0;
        ticks(10);
        kill("ml");
        ticks(5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_vals("rst_lock");
        tick();
        check("rst_lock_idle", int'(state), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
